// File: rtl/debug_mem_dumper.sv
// Streams every data memory byte, address 0 upward, to the debug transmitter.
// Optional trailing XOR checksum byte when DUMP_CHECKSUM_EN is defined.
module debug_mem_dumper #(
    parameter int MEMORY_WIDTH = 8,
    parameter int MEMORY_DEPTH = 128,
    parameter int NB_ADDR      = 7
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_start,
    output logic                    o_mem_enable,
    output logic                    o_read_enable,
    output logic [NB_ADDR-1:0]      o_read_address,
    input  logic [MEMORY_WIDTH-1:0] i_byte_data,
    output logic [MEMORY_WIDTH-1:0] o_tx_data,
    output logic                    o_tx_valid,
    input  logic                    i_tx_ready,
    output logic                    o_busy,
    output logic                    o_done
);

    localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(MEMORY_DEPTH - 1);
    localparam logic [NB_ADDR-1:0] ADDR_ONE  = NB_ADDR'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_LATCH,
        ST_SEND,
        ST_FIN
`ifdef DUMP_CHECKSUM_EN
        ,
        ST_CSUM
`endif
    } state_t;

    state_t                  state_q, state_d;
    logic [NB_ADDR-1:0]      addr_q, addr_d;
    logic [MEMORY_WIDTH-1:0] tx_data_q, tx_data_d;
`ifdef DUMP_CHECKSUM_EN
    logic [MEMORY_WIDTH-1:0] csum_q, csum_d;
`endif

    // State, address counter and outgoing byte registers
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            tx_data_q <= '0;
`ifdef DUMP_CHECKSUM_EN
            csum_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            tx_data_q <= tx_data_d;
`ifdef DUMP_CHECKSUM_EN
            csum_q    <= csum_d;
`endif
        end
    end

    // Next-state: one read strobe, one latch cycle, then hold until accepted
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        tx_data_d = tx_data_q;
`ifdef DUMP_CHECKSUM_EN
        csum_d    = csum_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_REQ;
                    addr_d  = '0;
`ifdef DUMP_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            ST_REQ: begin
                state_d = ST_LATCH;
            end
            ST_LATCH: begin
                tx_data_d = i_byte_data;
                state_d   = ST_SEND;
            end
            ST_SEND: begin
                if (i_tx_ready) begin
`ifdef DUMP_CHECKSUM_EN
                    csum_d = csum_q ^ tx_data_q;
`endif
                    if (addr_q == LAST_ADDR) begin
`ifdef DUMP_CHECKSUM_EN
                        tx_data_d = csum_q ^ tx_data_q;
                        state_d   = ST_CSUM;
`else
                        state_d   = ST_FIN;
`endif
                    end else begin
                        addr_d  = addr_q + ADDR_ONE;
                        state_d = ST_REQ;
                    end
                end
            end
`ifdef DUMP_CHECKSUM_EN
            ST_CSUM: begin
                if (i_tx_ready) begin
                    state_d = ST_FIN;
                end
            end
`endif
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign o_mem_enable   = (state_q == ST_REQ);
    assign o_read_enable  = (state_q == ST_REQ);
    assign o_read_address = (state_q == ST_REQ) ? addr_q : '0;
    assign o_tx_data      = tx_data_q;
`ifdef DUMP_CHECKSUM_EN
    assign o_tx_valid     = (state_q == ST_SEND) || (state_q == ST_CSUM);
`else
    assign o_tx_valid     = (state_q == ST_SEND);
`endif
    assign o_busy         = (state_q != ST_IDLE);
    assign o_done         = (state_q == ST_FIN);

endmodule
